// File: rtl/banco_registros_param_pkg.sv
// Shared types and default sizes for the parametrised register bank.
package banco_pkg;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} clr_state_t;
  localparam int W_DEF = 32;
  localparam int A_DEF = 5;
endpackage

// File: rtl/banco_registros_param_if.sv
// Read/write/clear bus of the register bank; master drives requests, slave answers.
interface banco_if
  import banco_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int A = A_DEF
);
  logic [A-1:0] addr_rs1;
  logic [A-1:0] addr_rs2;
  logic [A-1:0] addr_rd;
  logic [W-1:0] data_in;
  logic         WE;
  logic         clr_req;
  logic [W-1:0] rs1;
  logic [W-1:0] rs2;
  logic         wr_ready;
  logic         busy;
  logic         clr_done;

  modport master (
    output addr_rs1, addr_rs2, addr_rd, data_in, WE, clr_req,
    input  rs1, rs2, wr_ready, busy, clr_done
  );
  modport slave (
    input  addr_rs1, addr_rs2, addr_rd, data_in, WE, clr_req,
    output rs1, rs2, wr_ready, busy, clr_done
  );
endinterface

// File: rtl/banco_registros_param_clr_fsm.sv
// Clear-sweep controller: walks ptr over every register once, then pulses clr_done.
module banco_clr_fsm
  import banco_pkg::*;
#(
  parameter int A = A_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_req,
  output logic         busy,
  output logic         wr_ready,
  output logic         clr_done,
  output logic         clr_en,
  output logic [A-1:0] clr_addr
);
  localparam logic [A-1:0] LAST = {A{1'b1}};

  clr_state_t   state, nstate;
  logic [A-1:0] ptr, nptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= nstate;
      ptr   <= nptr;
    end
  end

  always_comb begin
    nstate   = state;
    nptr     = ptr;
    busy     = 1'b0;
    wr_ready = 1'b1;
    clr_done = 1'b0;
    clr_en   = 1'b0;
    clr_addr = ptr;
    case (state)
      IDLE: begin
        if (clr_req) begin
          nstate = SWEEP;
          nptr   = '0;
        end
      end
      SWEEP: begin
        busy     = 1'b1;
        wr_ready = 1'b0;
        clr_en   = 1'b1;
        // explicit terminal compare; ptr is reset on exit rather than left to wrap
        if (ptr == LAST) begin
          nstate = DONE;
          nptr   = '0;
        end else begin
          nptr = ptr + A'(1);
        end
      end
      DONE: begin
        clr_done = 1'b1;
        nptr     = '0;
        nstate   = clr_req ? SWEEP : IDLE;
      end
      default: begin
        nstate = IDLE;
        nptr   = '0;
      end
    endcase
  end
endmodule

// File: rtl/banco_registros_param.sv
// Register bank: two combinational read ports, one synchronous write port, clear sweep.
module banco_registros_param
  import banco_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int A        = A_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic   clk,
  input logic   rst,
  banco_if.slave bus
);
  localparam int DEPTH = 2**A;
  localparam int NRD   = 2;

  logic [W-1:0] mem [DEPTH];

  logic         clr_en;
  logic [A-1:0] clr_addr;
  logic         wr_acc, wr_keep;

  logic [NRD-1:0][A-1:0] raddr;
  logic [NRD-1:0][W-1:0] rdata;

  banco_clr_fsm #(.A(A)) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (bus.clr_req),
    .busy     (bus.busy),
    .wr_ready (bus.wr_ready),
    .clr_done (bus.clr_done),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  assign wr_acc  = bus.WE & bus.wr_ready;
  assign wr_keep = wr_acc & ~((ZERO_REG != 0) && (bus.addr_rd == '0));

  // sweep clear wins over a write; in practice they never coincide since wr_ready=0 in SWEEP
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_en) begin
      mem[clr_addr] <= '0;
    end else if (wr_keep) begin
      mem[bus.addr_rd] <= bus.data_in;
    end
  end

  assign raddr = {bus.addr_rs2, bus.addr_rs1};

  always_comb begin
    rdata = '0;
    for (int p = 0; p < NRD; p++) begin
      rdata[p] = mem[raddr[p]];
      if ((BYPASS != 0) && wr_acc && (bus.addr_rd == raddr[p])) rdata[p] = bus.data_in;
      if ((ZERO_REG != 0) && (raddr[p] == '0)) rdata[p] = '0;
    end
  end

  assign bus.rs1 = rdata[0];
  assign bus.rs2 = rdata[1];
endmodule
